roce_tx_sink: RTL and testbench



---
 rtl/roce_tx_sink.sv | 145 ++++++++++++++
 tb/tb_roce_tx_sink.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/roce_tx_sink.sv
// Sink for the RoCE transmit role interface: takes one meta word plus its payload
// beats and answers each command with a 128-bit completion word on the status stream.
module roce_tx_sink #(
    parameter int C_S_AXIS_TX_META_TDATA_WIDTH   = 256,
    parameter int C_S_AXIS_TX_DATA_TDATA_WIDTH   = 512,
    parameter int C_M_AXIS_TX_STATUS_TDATA_WIDTH = 512
) (
    input  logic                                          ap_clk,
    input  logic                                          ap_rst_n,
    input  logic                                          s_axis_tx_meta_tvalid,
    output logic                                          s_axis_tx_meta_tready,
    input  logic [C_S_AXIS_TX_META_TDATA_WIDTH-1:0]       s_axis_tx_meta_tdata,
    input  logic [C_S_AXIS_TX_META_TDATA_WIDTH/8-1:0]     s_axis_tx_meta_tkeep,
    input  logic                                          s_axis_tx_meta_tlast,
    input  logic                                          s_axis_tx_data_tvalid,
    output logic                                          s_axis_tx_data_tready,
    input  logic [C_S_AXIS_TX_DATA_TDATA_WIDTH-1:0]       s_axis_tx_data_tdata,
    input  logic [C_S_AXIS_TX_DATA_TDATA_WIDTH/8-1:0]     s_axis_tx_data_tkeep,
    input  logic                                          s_axis_tx_data_tlast,
    output logic                                          m_axis_tx_status_tvalid,
    input  logic                                          m_axis_tx_status_tready,
    output logic [C_M_AXIS_TX_STATUS_TDATA_WIDTH-1:0]     m_axis_tx_status_tdata,
    output logic [C_M_AXIS_TX_STATUS_TDATA_WIDTH/8-1:0]   m_axis_tx_status_tkeep,
    output logic                                          m_axis_tx_status_tlast,
    output logic [31:0]                                   xfer_count,
    output logic [31:0]                                   err_count
);

    localparam int META_W      = C_S_AXIS_TX_META_TDATA_WIDTH;
    localparam int DATA_KEEP_W = C_S_AXIS_TX_DATA_TDATA_WIDTH / 8;
    localparam int STAT_W      = C_M_AXIS_TX_STATUS_TDATA_WIDTH;
    localparam int STAT_KEEP_W = C_M_AXIS_TX_STATUS_TDATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_STATUS = 2'd2
    } state_t;

    function automatic logic [31:0] popcount(input logic [DATA_KEEP_W-1:0] k);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_KEEP_W; i++) begin
            cnt = cnt + {31'd0, k[i]};
        end
        return cnt;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    state_t      state, state_nxt;
    logic        meta_tready_q, data_tready_q, status_tvalid_q;
    logic        meta_hs, data_hs, status_hs;
    logic [31:0] len_q, byte_cnt_q;
    logic [23:0] qpn_q;
    logic [7:0]  opcode_q;
    logic [31:0] xfer_count_q, err_count_q;
    logic        len_err, bad_op;
    logic [127:0] status_word;

    assign meta_hs   = s_axis_tx_meta_tvalid & meta_tready_q;
    assign data_hs   = s_axis_tx_data_tvalid & data_tready_q;
    assign status_hs = status_tvalid_q & m_axis_tx_status_tready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (meta_hs) begin
                    state_nxt = (s_axis_tx_meta_tdata[31:0] != 32'd0) ? S_DATA : S_STATUS;
                end
            end
            S_DATA: begin
                // Payload runs to tlast no matter what len said; mismatch shows up as len_err.
                if (data_hs && s_axis_tx_data_tlast) begin
                    state_nxt = S_STATUS;
                end
            end
            S_STATUS: begin
                if (status_hs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control: handshake flags are registered copies of the next state, so all
    // of them sit at 0 during reset and meta_tready rises on the first edge after it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state           <= S_IDLE;
            meta_tready_q   <= 1'b0;
            data_tready_q   <= 1'b0;
            status_tvalid_q <= 1'b0;
            xfer_count_q    <= '0;
            err_count_q     <= '0;
        end else begin
            state           <= state_nxt;
            meta_tready_q   <= (state_nxt == S_IDLE);
            data_tready_q   <= (state_nxt == S_DATA);
            status_tvalid_q <= (state_nxt == S_STATUS);
            if (status_hs) begin
                xfer_count_q <= xfer_count_q + 32'd1;
                if (len_err || bad_op) begin
                    err_count_q <= sat_add32(err_count_q, 32'd1);
                end
            end
        end
    end

    // Datapath: command fields and byte counter, only meaningful while a command is open.
    always_ff @(posedge ap_clk) begin
        if (meta_hs) begin
            len_q      <= s_axis_tx_meta_tdata[31:0];
            qpn_q      <= s_axis_tx_meta_tdata[55:32];
            opcode_q   <= s_axis_tx_meta_tdata[63:56];
            byte_cnt_q <= '0;
        end else if (data_hs) begin
            byte_cnt_q <= sat_add32(byte_cnt_q, popcount(s_axis_tx_data_tkeep));
        end
    end

    assign len_err     = (byte_cnt_q != len_q);
    assign bad_op      = (opcode_q > 8'h03);
    assign status_word = {xfer_count_q, 30'd0, bad_op, len_err, opcode_q, qpn_q, byte_cnt_q};

    assign s_axis_tx_meta_tready   = meta_tready_q;
    assign s_axis_tx_data_tready   = data_tready_q;
    assign m_axis_tx_status_tvalid = status_tvalid_q;
    assign m_axis_tx_status_tdata  = status_tvalid_q ? {{(STAT_W-128){1'b0}}, status_word} : '0;
    assign m_axis_tx_status_tkeep  = {STAT_KEEP_W{status_tvalid_q}};
    assign m_axis_tx_status_tlast  = status_tvalid_q;
    assign xfer_count              = xfer_count_q;
    assign err_count               = err_count_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axis_tx_meta_tkeep, s_axis_tx_meta_tlast,
                         s_axis_tx_meta_tdata[META_W-1:64], s_axis_tx_data_tdata};

endmodule

// File: tb/tb_roce_tx_sink.sv
// Directed and throttled-random bench for roce_tx_sink; inputs change and outputs
// are sampled on the falling clock edge.
module tb_roce_tx_sink;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n;
    logic         meta_tvalid, meta_tready, meta_tlast;
    logic [255:0] meta_tdata;
    logic [31:0]  meta_tkeep;
    logic         data_tvalid, data_tready, data_tlast;
    logic [511:0] data_tdata;
    logic [63:0]  data_tkeep;
    logic         status_tvalid, status_tready, status_tlast;
    logic [511:0] status_tdata;
    logic [63:0]  status_tkeep;
    logic [31:0]  xfer_count, err_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ap_clk = ~ap_clk;

    roce_tx_sink dut (
        .ap_clk                  (ap_clk),
        .ap_rst_n                (ap_rst_n),
        .s_axis_tx_meta_tvalid   (meta_tvalid),
        .s_axis_tx_meta_tready   (meta_tready),
        .s_axis_tx_meta_tdata    (meta_tdata),
        .s_axis_tx_meta_tkeep    (meta_tkeep),
        .s_axis_tx_meta_tlast    (meta_tlast),
        .s_axis_tx_data_tvalid   (data_tvalid),
        .s_axis_tx_data_tready   (data_tready),
        .s_axis_tx_data_tdata    (data_tdata),
        .s_axis_tx_data_tkeep    (data_tkeep),
        .s_axis_tx_data_tlast    (data_tlast),
        .m_axis_tx_status_tvalid (status_tvalid),
        .m_axis_tx_status_tready (status_tready),
        .m_axis_tx_status_tdata  (status_tdata),
        .m_axis_tx_status_tkeep  (status_tkeep),
        .m_axis_tx_status_tlast  (status_tlast),
        .xfer_count              (xfer_count),
        .err_count               (err_count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_word(input logic [31:0] seq, input logic bad,
                                             input logic lerr, input logic [7:0] op,
                                             input logic [23:0] qpn, input logic [31:0] cnt);
        return {seq, 30'd0, bad, lerr, op, qpn, cnt};
    endfunction

    task automatic do_reset();
        ap_rst_n = 1'b0;
        meta_tvalid = 1'b0;
        data_tvalid = 1'b0;
        data_tlast = 1'b0;
        status_tready = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        chk("rdy_hold_after_rst", meta_tready, 1'b0);
        @(posedge ap_clk);
        #1;
        chk("rdy_first_edge", meta_tready, 1'b1);
        @(negedge ap_clk);
    endtask

    task automatic send_meta(input logic [31:0] len, input logic [23:0] qpn, input logic [7:0] op,
                             input bit throttle);
        int t = 0;
        if (throttle) begin
            meta_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge ap_clk);
        end
        meta_tdata  = {192'd0, op, qpn, len};
        meta_tvalid = 1'b1;
        while (!meta_tready && t < 2000) begin
            @(negedge ap_clk);
            t++;
        end
        if (!meta_tready) chk("meta_timeout", meta_tready, 1'b1);
        @(negedge ap_clk);
        meta_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] keep, input logic last, input bit throttle);
        int t = 0;
        if (throttle) begin
            data_tvalid = 1'b0;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge ap_clk);
        end
        data_tkeep  = keep;
        data_tlast  = last;
        data_tdata  = {16{$urandom}};
        data_tvalid = 1'b1;
        while (!data_tready && t < 2000) begin
            @(negedge ap_clk);
            t++;
        end
        if (!data_tready) chk("data_timeout", data_tready, 1'b1);
        @(negedge ap_clk);
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
    endtask

    task automatic recv_status(output logic [127:0] w, input bit throttle);
        int t = 0;
        if (throttle) repeat ($urandom_range(0, 2)) @(negedge ap_clk);
        status_tready = 1'b1;
        while (!status_tvalid && t < 2000) begin
            @(negedge ap_clk);
            t++;
        end
        if (!status_tvalid) chk("status_timeout", status_tvalid, 1'b1);
        w = status_tdata[127:0];
        @(negedge ap_clk);
        status_tready = 1'b0;
    endtask

    localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [127:0] w;
        logic [127:0] exp_w;
        logic [31:0]  len;
        logic [23:0]  qpn;
        logic [7:0]   op;
        int           beats, rem;
        bit           rnd_ok;

        ap_rst_n    = 1'b0;
        meta_tvalid = 1'b0;
        meta_tdata  = '0;
        meta_tkeep  = '1;
        meta_tlast  = 1'b1;
        data_tvalid = 1'b0;
        data_tdata  = '0;
        data_tkeep  = '0;
        data_tlast  = 1'b0;
        status_tready = 1'b0;
        repeat (3) @(negedge ap_clk);

        chk("rst_meta_tready", meta_tready, 1'b0);
        chk("rst_data_tready", data_tready, 1'b0);
        chk("rst_status_tvalid", status_tvalid, 1'b0);
        chk("rst_status_tdata", {127'd0, |status_tdata}, 128'd0);
        chk("rst_status_tkeep", status_tkeep, 64'd0);
        chk("rst_status_tlast", status_tlast, 1'b0);
        chk("rst_xfer_count", xfer_count, 32'd0);
        chk("rst_err_count", err_count, 32'd0);

        do_reset();

        // Two commands: 128 bytes in two beats, then a zero-length one.
        send_meta(32'd128, 24'h5, 8'h01, 1'b0);
        chk("t1_data_tready", data_tready, 1'b1);
        chk("t1_meta_tready", meta_tready, 1'b0);
        send_beat(FULL, 1'b0, 1'b0);
        chk("t1_mid_status_tvalid", status_tvalid, 1'b0);
        send_beat(FULL, 1'b1, 1'b0);
        chk("t1_last_data_tready", data_tready, 1'b0);
        chk("t1_last_status_tvalid", status_tvalid, 1'b1);
        chk("t1_status_tkeep", status_tkeep, FULL);
        chk("t1_status_tlast", status_tlast, 1'b1);
        chk("t1_status_hi", {127'd0, |status_tdata[511:128]}, 128'd0);
        recv_status(w, 1'b0);
        chk("t1_word", w, mk_word(32'd0, 1'b0, 1'b0, 8'h01, 24'h5, 32'd128));
        chk("t1_meta_tready_after", meta_tready, 1'b1);
        chk("t1_xfer_count", xfer_count, 32'd1);

        send_meta(32'd0, 24'h6, 8'h00, 1'b0);
        chk("t2_status_next_cycle", status_tvalid, 1'b1);
        chk("t2_data_tready", data_tready, 1'b0);
        recv_status(w, 1'b0);
        chk("t2_word", w, mk_word(32'd1, 1'b0, 1'b0, 8'h00, 24'h6, 32'd0));
        chk("t2_xfer_count", xfer_count, 32'd2);
        chk("t2_err_count", err_count, 32'd0);

        // Short payload: 64 + 20 bytes against len 100.
        do_reset();
        send_meta(32'd100, 24'h7, 8'h02, 1'b0);
        send_beat(FULL, 1'b0, 1'b0);
        send_beat(64'h0000_0000_000F_FFFF, 1'b1, 1'b0);
        recv_status(w, 1'b0);
        chk("t3_word", w, mk_word(32'd0, 1'b0, 1'b1, 8'h02, 24'h7, 32'd84));
        chk("t3_err_count", err_count, 32'd1);

        // Illegal opcode still consumes payload and completes.
        do_reset();
        send_meta(32'd64, 24'h8, 8'h7F, 1'b0);
        send_beat(FULL, 1'b1, 1'b0);
        recv_status(w, 1'b0);
        chk("t4_word", w, mk_word(32'd0, 1'b1, 1'b0, 8'h7F, 24'h8, 32'd64));
        chk("t4_err_count", err_count, 32'd1);

        // Back-pressure on status with data and meta pushing meanwhile.
        send_meta(32'd64, 24'h9, 8'h00, 1'b0);
        send_beat(FULL, 1'b1, 1'b0);
        exp_w = mk_word(32'd1, 1'b0, 1'b0, 8'h00, 24'h9, 32'd64);
        meta_tdata  = {192'd0, 8'h03, 24'hA, 32'd0};
        meta_tvalid = 1'b1;
        data_tkeep  = FULL;
        for (int i = 0; i < 10; i++) begin
            data_tvalid = 1'($urandom_range(0, 1));
            chk("t5_stall_tvalid", status_tvalid, 1'b1);
            chk("t5_stall_word", status_tdata[127:0], exp_w);
            chk("t5_stall_data_tready", data_tready, 1'b0);
            chk("t5_stall_meta_tready", meta_tready, 1'b0);
            @(negedge ap_clk);
        end
        data_tvalid   = 1'b0;
        status_tready = 1'b1;
        @(negedge ap_clk);
        status_tready = 1'b0;
        chk("t5_after_hs_tvalid", status_tvalid, 1'b0);
        chk("t5_after_hs_meta_tready", meta_tready, 1'b1);
        chk("t5_after_hs_xfer", xfer_count, 32'd2);
        @(negedge ap_clk);
        meta_tvalid = 1'b0;
        chk("t5_meta_taken", status_tvalid, 1'b1);
        recv_status(w, 1'b0);
        chk("t5_second_word", w, mk_word(32'd2, 1'b0, 1'b0, 8'h03, 24'hA, 32'd0));
        chk("t5_xfer_count", xfer_count, 32'd3);

        // Reset in the middle of a five-beat payload.
        send_meta(32'd320, 24'hB, 8'h01, 1'b0);
        repeat (3) send_beat(FULL, 1'b0, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        chk("t6_async_data_tready", data_tready, 1'b0);
        chk("t6_async_meta_tready", meta_tready, 1'b0);
        chk("t6_async_status_tvalid", status_tvalid, 1'b0);
        chk("t6_async_xfer", xfer_count, 32'd0);
        do_reset();
        send_meta(32'd64, 24'hC, 8'h00, 1'b0);
        send_beat(FULL, 1'b1, 1'b0);
        recv_status(w, 1'b0);
        chk("t6_word", w, mk_word(32'd0, 1'b0, 1'b0, 8'h00, 24'hC, 32'd64));
        chk("t6_xfer_count", xfer_count, 32'd1);

        // Throttled random traffic; mostly short commands to stay within the cycle budget.
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            len = (i % 50 == 0) ? $urandom_range(1, 16384) : $urandom_range(1, 1024);
            qpn = 24'($urandom);
            op  = 8'($urandom_range(0, 3));
            beats = (int'(len) + 63) / 64;
            rem   = int'(len) - 64 * (beats - 1);
            send_meta(len, qpn, op, 1'b1);
            for (int b = 0; b < beats; b++) begin
                if (b == beats - 1)
                    send_beat((rem == 64) ? FULL : ((64'd1 << rem) - 64'd1), 1'b1, 1'b1);
                else
                    send_beat(FULL, 1'b0, 1'b1);
            end
            recv_status(w, 1'b1);
            exp_w  = mk_word(32'(i), 1'b0, 1'b0, op, qpn, len);
            rnd_ok = (w === exp_w);
            if (!rnd_ok || i % 100 == 0) chk("rnd_word", w, exp_w);
        end
        chk("rnd_xfer_count", xfer_count, 32'd1000);
        chk("rnd_err_count", err_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
